// File: rtl/seg_scan_decoder.sv
// Readback tap for a multiplexed 7-segment scan bus: debounces each digit window,
// decodes the segment pattern back to a nibble and publishes complete 8-digit frames.
module seg_scan_decoder #(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  led_en,
   input  logic [7:0]  led_seg,
   output logic [31:0] value,
   output logic [7:0]  dp,
   output logic [7:0]  blank,
   output logic [7:0]  err,
   output logic        frame_done,
   output logic        stalled
);

   localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYC);
   localparam logic [7:0]  STABLE_M1  = 8'(STABLE_CYC - 1);
   localparam logic [19:0] TIMEOUT_V  = 20'(TIMEOUT_CYC);

   // Returns {blank, err, nibble}; blank and undecodable patterns both yield nibble 0.
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'b1111110: r = 6'h00;
         7'b0110000: r = 6'h01;
         7'b1101101: r = 6'h02;
         7'b1111001: r = 6'h03;
         7'b0110011: r = 6'h04;
         7'b1011011: r = 6'h05;
         7'b1011111: r = 6'h06;
         7'b1110000: r = 6'h07;
         7'b1111111: r = 6'h08;
         7'b1110011: r = 6'h09;
         7'b1110111: r = 6'h0A;
         7'b0011111: r = 6'h0B;
         7'b0001101: r = 6'h0C;
         7'b0111101: r = 6'h0D;
         7'b1001111: r = 6'h0E;
         7'b1000111: r = 6'h0F;
         7'b0000000: r = 6'b10_0000;
         default:    r = 6'b01_0000;
      endcase
      return r;
   endfunction

   logic [7:0]       s_en_q, s_en_d;
   logic [7:0]       s_seg_q, s_seg_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [19:0]      idle_q, idle_d;
   logic [7:0]       seen_q, seen_d;
   logic [7:0][3:0]  slot_nib_q, slot_nib_d;
   logic [7:0]       slot_dp_q, slot_dp_d;
   logic [7:0]       slot_blank_q, slot_blank_d;
   logic [7:0]       slot_err_q, slot_err_d;
   logic [31:0]      value_q, value_d;
   logic [7:0]       dp_q, dp_d;
   logic [7:0]       blank_q, blank_d;
   logic [7:0]       err_q, err_d;
   logic             frame_done_q, frame_done_d;
   logic             stalled_q, stalled_d;

   logic [7:0] en_act;
   logic [7:0] seen_upd;
   logic [5:0] dec;
   logic       onehot;
   logic       match;
   logic       capture;

   always_comb begin
      en_act   = ~led_en;
      onehot   = (en_act != 8'h00) && ((en_act & (en_act - 8'd1)) == 8'h00);
      match    = onehot && (led_en == s_en_q) && (led_seg == s_seg_q);
      capture  = match && (cnt_q == STABLE_M1);
      dec      = decode(led_seg[7:1]);
      seen_upd = seen_q | en_act;

      s_en_d       = led_en;
      s_seg_d      = led_seg;
      cnt_d        = match ? ((cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1) : 8'd0;
      idle_d       = idle_q;
      seen_d       = seen_q;
      slot_nib_d   = slot_nib_q;
      slot_dp_d    = slot_dp_q;
      slot_blank_d = slot_blank_q;
      slot_err_d   = slot_err_q;
      value_d      = value_q;
      dp_d         = dp_q;
      blank_d      = blank_q;
      err_d        = err_q;
      frame_done_d = 1'b0;
      stalled_d    = stalled_q;

      if (capture) begin
         for (int i = 0; i < 8; i++) begin
            if (en_act[i]) begin
               slot_nib_d[i]   = dec[3:0];
               slot_dp_d[i]    = led_seg[0];
               slot_blank_d[i] = dec[5];
               slot_err_d[i]   = dec[4];
            end
         end
         seen_d    = seen_upd;
         idle_d    = 20'd0;
         stalled_d = 1'b0;
         // Frame publishes from the next-state slots so the eighth digit is included.
         if (&seen_upd) begin
            value_d      = slot_nib_d;
            dp_d         = slot_dp_d;
            blank_d      = slot_blank_d;
            err_d        = slot_err_d;
            frame_done_d = 1'b1;
            seen_d       = 8'h00;
         end
      end else begin
         idle_d = (idle_q == TIMEOUT_V) ? idle_q : idle_q + 20'd1;
         if (idle_d == TIMEOUT_V) begin
            stalled_d = 1'b1;
            seen_d    = 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_en_q       <= 8'hFF;
         s_seg_q      <= 8'h00;
         cnt_q        <= 8'd0;
         idle_q       <= 20'd0;
         seen_q       <= 8'h00;
         slot_nib_q   <= '0;
         slot_dp_q    <= 8'h00;
         slot_blank_q <= 8'h00;
         slot_err_q   <= 8'h00;
         value_q      <= 32'h0;
         dp_q         <= 8'h00;
         blank_q      <= 8'h00;
         err_q        <= 8'h00;
         frame_done_q <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         s_en_q       <= s_en_d;
         s_seg_q      <= s_seg_d;
         cnt_q        <= cnt_d;
         idle_q       <= idle_d;
         seen_q       <= seen_d;
         slot_nib_q   <= slot_nib_d;
         slot_dp_q    <= slot_dp_d;
         slot_blank_q <= slot_blank_d;
         slot_err_q   <= slot_err_d;
         value_q      <= value_d;
         dp_q         <= dp_d;
         blank_q      <= blank_d;
         err_q        <= err_d;
         frame_done_q <= frame_done_d;
         stalled_q    <= stalled_d;
      end
   end

   assign value      = value_q;
   assign dp         = dp_q;
   assign blank      = blank_q;
   assign err        = err_q;
   assign frame_done = frame_done_q;
   assign stalled    = stalled_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives digit scan windows on the display bus
// and compares published frames against hand-computed values.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  led_en;
   logic [7:0]  led_seg;
   logic [31:0] value;
   logic [7:0]  dp;
   logic [7:0]  blank;
   logic [7:0]  err;
   logic        frame_done;
   logic        stalled;

   int checks   = 0;
   int failures = 0;

   seg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
      .clk        (clk),
      .rst        (rst),
      .led_en     (led_en),
      .led_seg    (led_seg),
      .value      (value),
      .dp         (dp),
      .blank      (blank),
      .err        (err),
      .frame_done (frame_done),
      .stalled    (stalled)
   );

   always #5 clk = ~clk;

   // Nibble-to-segment encoder (what the SoC scanner drives), dp appended as bit 0.
   function automatic logic [7:0] seg_of(input logic [3:0] n, input logic d);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;  4'h9: s = 7'b1110011;
         4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
         4'hC: s = 7'b0001101;  4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;  default: s = 7'b1000111;
      endcase
      return {s, d};
   endfunction

   task automatic scan_digit(input int d, input logic [7:0] seg, input int hold, output int fd);
      fd = 0;
      led_en  = ~(8'h01 << d);
      led_seg = seg;
      repeat (hold) begin
         @(posedge clk); #1;
         if (frame_done) fd++;
      end
   endtask

   task automatic scan_range(input logic [31:0] v, input int first, input int last, output int fd);
      int f;
      fd = 0;
      for (int d = first; d <= last; d++) begin
         scan_digit(d, seg_of(v[4*d +: 4], 1'b0), 6, f);
         fd += f;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if (value !== 32'h0 || dp !== 8'h0 || blank !== 8'h0 || err !== 8'h0 ||
          frame_done !== 1'b0 || stalled !== 1'b0) begin
         failures++;
         $display("FAIL %s: value=%h dp=%h blank=%h err=%h fd=%b stalled=%b, all required 0",
                  tag, value, dp, blank, err, frame_done, stalled);
      end
   endtask

   task automatic test_reset();
      led_en  = 8'hFF;
      led_seg = 8'h00;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_outputs_zero("reset_state");
   endtask

   task automatic test_basic_frame();
      int fd_a, fd_b;
      scan_range(32'h1234ABCD, 0, 6, fd_a);
      scan_range(32'h1234ABCD, 7, 7, fd_b);
      checks++;
      if (fd_a !== 0) begin failures++; $display("FAIL basic_early_fd: got %0d pulses, want 0", fd_a); end
      checks++;
      if (fd_b !== 1) begin failures++; $display("FAIL basic_fd: got %0d pulses, want 1", fd_b); end
      checks++;
      if (value !== 32'h1234ABCD) begin failures++; $display("FAIL basic_value: got %h want 1234abcd", value); end
      checks++;
      if (blank !== 8'h00 || err !== 8'h00 || dp !== 8'h00 || stalled !== 1'b0) begin
         failures++;
         $display("FAIL basic_flags: blank=%h err=%h dp=%h stalled=%b, want 0", blank, err, dp, stalled);
      end
   endtask

   task automatic test_glitch();
      int fd_a, fd_b, f;
      logic [31:0] v = 32'h89AB3DEF;
      scan_range(v, 0, 2, fd_a);
      scan_digit(3, seg_of(4'h3, 1'b0), 3, f);
      fd_a += f;
      scan_range(v, 4, 7, f);
      fd_a += f;
      checks++;
      if (fd_a !== 0) begin failures++; $display("FAIL glitch_no_frame: got %0d pulses, want 0", fd_a); end
      checks++;
      if (value !== 32'h1234ABCD) begin failures++; $display("FAIL glitch_value_held: got %h want 1234abcd", value); end
      scan_digit(3, seg_of(4'h3, 1'b0), 6, fd_b);
      checks++;
      if (fd_b !== 1) begin failures++; $display("FAIL glitch_rescan_fd: got %0d pulses, want 1", fd_b); end
      checks++;
      if (value !== v) begin failures++; $display("FAIL glitch_value: got %h want %h", value, v); end
   endtask

   task automatic test_err_blank_dp();
      int fd, f;
      logic [31:0] v = 32'h76543210;
      fd = 0;
      for (int d = 0; d < 8; d++) begin
         if (d == 5)      scan_digit(d, 8'b1010101_0, 6, f);
         else if (d == 2) scan_digit(d, 8'b0000000_1, 6, f);
         else             scan_digit(d, seg_of(v[4*d +: 4], 1'b0), 6, f);
         fd += f;
      end
      checks++;
      if (fd !== 1) begin failures++; $display("FAIL ebd_fd: got %0d pulses, want 1", fd); end
      checks++;
      if (err !== 8'h20) begin failures++; $display("FAIL ebd_err: got %h want 20", err); end
      checks++;
      if (blank !== 8'h04) begin failures++; $display("FAIL ebd_blank: got %h want 04", blank); end
      checks++;
      if (dp !== 8'h04) begin failures++; $display("FAIL ebd_dp: got %h want 04", dp); end
      checks++;
      if (value !== 32'h76043010) begin failures++; $display("FAIL ebd_value: got %h want 76043010", value); end
   endtask

   task automatic test_invalid_enables();
      int fd_a, fd_b, f;
      logic [31:0] v = 32'hFEDC0123;
      scan_range(v, 0, 3, fd_a);
      led_en  = 8'hFC;
      led_seg = seg_of(4'h8, 1'b0);
      repeat (20) begin
         @(posedge clk); #1;
         if (frame_done) fd_a++;
      end
      scan_range(v, 4, 6, f);
      fd_a += f;
      checks++;
      if (fd_a !== 0) begin failures++; $display("FAIL inval_no_frame: got %0d pulses, want 0", fd_a); end
      scan_range(v, 7, 7, fd_b);
      checks++;
      if (fd_b !== 1) begin failures++; $display("FAIL inval_fd: got %0d pulses, want 1", fd_b); end
      checks++;
      if (value !== v) begin failures++; $display("FAIL inval_value: got %h want %h", value, v); end
   endtask

   task automatic test_timeout();
      int fd, since;
      logic [31:0] v  = 32'h13579BDF;
      logic [31:0] v2 = 32'h2468ACE0;
      scan_range(v, 0, 6, fd);
      since   = -1;
      led_en  = ~8'h80;
      led_seg = seg_of(v[31:28], 1'b0);
      for (int e = 0; e < 300; e++) begin
         if (e == 6) led_en = 8'hFF;
         @(posedge clk); #1;
         if (frame_done) since = 0;
         else if (since >= 0) since++;
         if (stalled) break;
      end
      checks++;
      if (stalled !== 1'b1 || since !== 100) begin
         failures++;
         $display("FAIL timeout_latency: stalled=%b after %0d edges, want 1 after 100", stalled, since);
      end
      checks++;
      if (value !== v) begin failures++; $display("FAIL timeout_value_held: got %h want %h", value, v); end
      scan_range(v2, 0, 0, fd);
      checks++;
      if (stalled !== 1'b0) begin failures++; $display("FAIL timeout_clear: stalled=%b want 0", stalled); end
      scan_range(v2, 1, 7, fd);
      checks++;
      if (fd !== 1 || value !== v2) begin
         failures++;
         $display("FAIL timeout_new_frame: fd=%0d value=%h, want 1 and %h", fd, value, v2);
      end
   endtask

   task automatic test_reset_mid_scan();
      int fd;
      logic [31:0] v = 32'hA5A5C3C3;
      scan_range(32'h11111111, 0, 4, fd);
      led_en = 8'hFF;
      rst    = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_outputs_zero("midreset_state");
      scan_range(v, 5, 7, fd);
      checks++;
      if (fd !== 0 || value !== 32'h0) begin
         failures++;
         $display("FAIL midreset_partial: fd=%0d value=%h, want 0 and 0", fd, value);
      end
      scan_range(v, 0, 7, fd);
      checks++;
      if (fd !== 1 || value !== v) begin
         failures++;
         $display("FAIL midreset_frame: fd=%0d value=%h, want 1 and %h", fd, value, v);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_glitch();
      test_err_blank_dp();
      test_invalid_enables();
      test_timeout();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
